mips8_io_ctrl: RTL

MIPS8_IO_CTRL -- requirements
Module: mips8_io_ctrl

---
 rtl/mips8_io_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mips8_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips8_io_ctrl
//  Description : Wishbone-classic register slave that owns a 16-bit GPIO bank
//                shared between the management bus and a MIPS8 core. The OUT
//                register has two writers (Wishbone and core), resolved by a
//                1-bit round-robin owner on same-cycle conflicts.
//  Ports       : wb_clk_i / wb_rst_ni      clock, async active-low reset
//                wbs_*                     Wishbone classic slave
//                core_req_i/core_dat_i     core write request and data
//                core_gnt_o                one-cycle grant (write commits then)
//                io_in_i/io_out_o/io_oeb_o pad inputs, outputs, output-enable-bar
//                irq_o                     level interrupt (irq_en & |STAT)
//  Revision    : 1.0 - initial release
// ============================================================================
module mips8_io_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic        core_req_i,
    input  logic [15:0] core_dat_i,
    output logic        core_gnt_o,
    input  logic [15:0] io_in_i,
    output logic [15:0] io_out_o,
    output logic [15:0] io_oeb_o,
    output logic        irq_o
);

    localparam logic [2:0] c_off_ctrl = 3'd0;
    localparam logic [2:0] c_off_oeb  = 3'd1;
    localparam logic [2:0] c_off_out  = 3'd2;
    localparam logic [2:0] c_off_in   = 3'd3;
    localparam logic [2:0] c_off_stat = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_ctrl;
    logic [15:0] r_oeb;
    logic [15:0] r_out;
    logic [15:0] r_stat;
    logic [15:0] r_sync1;
    logic [15:0] r_sync2;
    logic [15:0] r_sync3;
    logic        r_last_wb;   // 1: Wishbone won the last conflict, 0: core did

    logic        w_match;
    logic [2:0]  w_off;
    logic        w_core_req_en;
    logic        w_wb_out_wr;
    logic        w_conflict;
    logic        w_wb_loses;
    logic        w_commit;
    logic        w_wr;
    logic        w_out_commit;
    logic [15:0] w_wdat;
    logic [1:0]  w_ctrl_nxt;
    logic [15:0] w_oeb_nxt;
    logic [15:0] w_out_nxt;
    logic [15:0] w_stat_clr;
    logic [15:0] w_stat_nxt;
    logic [15:0] w_rise;
    logic [15:0] w_rdata;
    logic        w_unused;

    // Only the low 16 data bits and lanes 0/1 reach any register.
    assign w_unused = ^{wbs_dat_i[31:16], wbs_sel_i[3:2], wbs_adr_i[1:0]};

    function automatic logic [15:0] f_lane_merge(input logic [15:0] old_val,
                                                 input logic [15:0] new_val,
                                                 input logic [1:0]  sel);
        logic [15:0] v;
        v = old_val;
        if (sel[0]) v[7:0]  = new_val[7:0];
        if (sel[1]) v[15:8] = new_val[15:8];
        return v;
    endfunction

    assign w_match       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign w_off         = wbs_adr_i[4:2];
    assign w_wdat        = wbs_dat_i[15:0];
    assign w_core_req_en = core_req_i & r_ctrl[0];
    assign w_wb_out_wr   = w_match & wbs_we_i & (w_off == c_off_out);
    assign w_conflict    = (r_state == ST_IDLE) & w_wb_out_wr & w_core_req_en;
    // The side that did not win last time wins now.
    assign w_wb_loses    = w_conflict & r_last_wb;

    // Bus FSM: a transfer is committed on the edge that enters ACK.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_match) begin
                    if (w_wb_loses) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_ACK;
                        w_commit    = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                w_state_nxt = ST_ACK;
                w_commit    = 1'b1;
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wr         = w_commit & wbs_we_i;
    assign w_out_commit = w_wr & (w_off == c_off_out);
    // The core loses only to a Wishbone OUT write committing this very cycle.
    assign core_gnt_o   = w_core_req_en & ~w_out_commit;

    assign w_rise = r_sync2 & ~r_sync3;

    always_comb begin
        w_ctrl_nxt = r_ctrl;
        w_oeb_nxt  = r_oeb;
        w_out_nxt  = r_out;
        w_stat_clr = 16'h0000;
        if (w_wr && (w_off == c_off_ctrl) && wbs_sel_i[0]) w_ctrl_nxt = w_wdat[1:0];
        if (w_wr && (w_off == c_off_oeb))  w_oeb_nxt  = f_lane_merge(r_oeb, w_wdat, wbs_sel_i[1:0]);
        if (w_wr && (w_off == c_off_stat)) w_stat_clr = f_lane_merge(16'h0000, w_wdat, wbs_sel_i[1:0]);
        if (core_gnt_o)                    w_out_nxt  = core_dat_i;
        else if (w_out_commit)             w_out_nxt  = f_lane_merge(r_out, w_wdat, wbs_sel_i[1:0]);
        // A new rising edge wins over a same-cycle clear.
        w_stat_nxt = (r_stat & ~w_stat_clr) | w_rise;
    end

    always_comb begin
        w_rdata = 16'h0000;
        case (w_off)
            c_off_ctrl: w_rdata = {14'h0000, r_ctrl};
            c_off_oeb:  w_rdata = r_oeb;
            c_off_out:  w_rdata = r_out;
            c_off_in:   w_rdata = r_sync2;
            c_off_stat: w_rdata = r_stat;
            default:    w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= ST_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0000_0000;
            r_ctrl    <= 2'b00;
            r_oeb     <= 16'hFFFF;
            r_out     <= 16'h0000;
            r_stat    <= 16'h0000;
            r_sync1   <= 16'h0000;
            r_sync2   <= 16'h0000;
            r_sync3   <= 16'h0000;
            r_last_wb <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            wbs_ack_o <= (w_state_nxt == ST_ACK);
            wbs_dat_o <= (w_commit && !wbs_we_i) ? {16'h0000, w_rdata} : 32'h0000_0000;
            r_ctrl    <= w_ctrl_nxt;
            r_oeb     <= w_oeb_nxt;
            r_out     <= w_out_nxt;
            r_stat    <= w_stat_nxt;
            r_sync1   <= io_in_i;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            if (w_conflict) r_last_wb <= ~w_wb_loses;
            // Built from next-state values so the interrupt tracks STAT without extra lag.
            irq_o     <= w_ctrl_nxt[1] & (|w_stat_nxt);
        end
    end

    assign io_out_o = r_out;
    assign io_oeb_o = r_oeb;

endmodule
`default_nettype wire
